// File: rtl/iir_sos_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iir_sos_sequencer: control FSM sharing one MAC across NUM_SEC DF-II      |
// | biquads. Optional bypass path enabled by macro IIR_SEQ_BYPASS_EN.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module iir_sos_sequencer #(
  parameter int NUM_SEC = 3,
  parameter int SEC_W   = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEC_W-1:0] sec_idx,
  output logic [2:0]       coef_idx,
  output logic             src_sel,
  output logic             acc_load,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             mac_sub,
  output logic             w0_ld,
  output logic             wst_we,
  output logic             wst_clr,
  output logic             sec_ld,
  output logic             busy
`ifdef IIR_SEQ_BYPASS_EN
  ,
  input  logic             bypass,
  output logic             out_byp
`endif
);

  typedef enum logic [3:0] {
    ST_INIT = 4'd0,
    ST_IDLE = 4'd1,
    ST_PRE  = 4'd2,
    ST_FB1  = 4'd3,
    ST_FB2  = 4'd4,
    ST_W0   = 4'd5,
    ST_FF0  = 4'd6,
    ST_FF1  = 4'd7,
    ST_FF2  = 4'd8,
    ST_UPD  = 4'd9,
    ST_DONE = 4'd10
  } state_t;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic       src_sel;
    logic       acc_load;
    logic       acc_clr;
    logic       mac_en;
    logic       mac_sub;
    logic       w0_ld;
    logic       wst_we;
    logic       wst_clr;
    logic       sec_ld;
    logic [2:0] coef_idx;
  } strb_t;

  localparam logic [SEC_W-1:0] c_last_sec = SEC_W'(NUM_SEC - 1);

  state_t           r_state, w_nxt_state;
  logic [SEC_W-1:0] r_sec, w_nxt_sec;
  strb_t            r_strb, w_nxt_strb;
`ifdef IIR_SEQ_BYPASS_EN
  logic             r_byp, w_nxt_byp;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state     <= ST_INIT;
      r_sec       <= '0;
      r_strb      <= '0;
      r_strb.busy <= 1'b1;
`ifdef IIR_SEQ_BYPASS_EN
      r_byp       <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_sec   <= w_nxt_sec;
      r_strb  <= w_nxt_strb;
`ifdef IIR_SEQ_BYPASS_EN
      r_byp   <= w_nxt_byp;
`endif
    end
  end

  // Next state is computed first, then strobes are decoded from it so the
  // registered strobes line up with the state they belong to.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sec   = r_sec;
    w_nxt_strb  = '0;
`ifdef IIR_SEQ_BYPASS_EN
    w_nxt_byp   = 1'b0;
`endif
    case (r_state)
      // wst_clr low here means the clear sweep has not started yet
      ST_INIT: if (r_strb.wst_clr) begin
        if (r_sec == c_last_sec) begin
          w_nxt_state = ST_IDLE;
          w_nxt_sec   = '0;
        end else begin
          w_nxt_sec = r_sec + SEC_W'(1);
        end
      end
      ST_IDLE: if (in_valid) begin
`ifdef IIR_SEQ_BYPASS_EN
        if (bypass) begin
          w_nxt_state = ST_DONE;
          w_nxt_byp   = 1'b1;
        end else begin
          w_nxt_state = ST_PRE;
        end
`else
        w_nxt_state = ST_PRE;
`endif
      end
      ST_PRE:  w_nxt_state = ST_FB1;
      ST_FB1:  w_nxt_state = ST_FB2;
      ST_FB2:  w_nxt_state = ST_W0;
      ST_W0:   w_nxt_state = ST_FF0;
      ST_FF0:  w_nxt_state = ST_FF1;
      ST_FF1:  w_nxt_state = ST_FF2;
      ST_FF2:  w_nxt_state = ST_UPD;
      ST_UPD: begin
        if (r_sec == c_last_sec) begin
          w_nxt_state = ST_DONE;
        end else begin
          w_nxt_state = ST_PRE;
          w_nxt_sec   = r_sec + SEC_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_nxt_state = ST_IDLE;
          w_nxt_sec   = '0;
        end else begin
`ifdef IIR_SEQ_BYPASS_EN
          w_nxt_byp = r_byp;
`endif
        end
      end
      default: begin
        w_nxt_state = ST_INIT;
        w_nxt_sec   = '0;
      end
    endcase

    w_nxt_strb.busy      = (w_nxt_state != ST_IDLE);
    w_nxt_strb.in_ready  = (w_nxt_state == ST_IDLE);
    w_nxt_strb.out_valid = (w_nxt_state == ST_DONE);
    case (w_nxt_state)
      ST_INIT: w_nxt_strb.wst_clr = 1'b1;
      ST_PRE: begin
        w_nxt_strb.acc_load = 1'b1;
        w_nxt_strb.src_sel  = (w_nxt_sec != '0);
      end
      ST_FB1: begin
        w_nxt_strb.mac_en   = 1'b1;
        w_nxt_strb.mac_sub  = 1'b1;
        w_nxt_strb.coef_idx = 3'd0;
      end
      ST_FB2: begin
        w_nxt_strb.mac_en   = 1'b1;
        w_nxt_strb.mac_sub  = 1'b1;
        w_nxt_strb.coef_idx = 3'd1;
      end
      ST_W0:  w_nxt_strb.w0_ld = 1'b1;
      ST_FF0: begin
        w_nxt_strb.acc_clr  = 1'b1;
        w_nxt_strb.mac_en   = 1'b1;
        w_nxt_strb.coef_idx = 3'd2;
      end
      ST_FF1: begin
        w_nxt_strb.mac_en   = 1'b1;
        w_nxt_strb.coef_idx = 3'd3;
      end
      ST_FF2: begin
        w_nxt_strb.mac_en   = 1'b1;
        w_nxt_strb.coef_idx = 3'd4;
      end
      ST_UPD: begin
        w_nxt_strb.wst_we = 1'b1;
        w_nxt_strb.sec_ld = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_ready  = r_strb.in_ready;
  assign out_valid = r_strb.out_valid;
  assign busy      = r_strb.busy;
  assign sec_idx   = r_sec;
  assign coef_idx  = r_strb.coef_idx;
  assign src_sel   = r_strb.src_sel;
  assign acc_load  = r_strb.acc_load;
  assign acc_clr   = r_strb.acc_clr;
  assign mac_en    = r_strb.mac_en;
  assign mac_sub   = r_strb.mac_sub;
  assign w0_ld     = r_strb.w0_ld;
  assign wst_we    = r_strb.wst_we;
  assign wst_clr   = r_strb.wst_clr;
  assign sec_ld    = r_strb.sec_ld;
`ifdef IIR_SEQ_BYPASS_EN
  assign out_byp   = r_byp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iir_sos_sequencer.sv
`default_nettype none
// Bench for iir_sos_sequencer: randomized handshakes, stalls and resets checked
// against an expected per-cycle transcript built from the section schedule.
module tb_iir_sos_sequencer;

  localparam int NUM_SEC = 3;

  typedef logic [17:0] obs_t;

  logic       clk;
  logic       nrst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] sec_idx;
  logic [2:0] coef_idx;
  logic       src_sel, acc_load, acc_clr, mac_en, mac_sub;
  logic       w0_ld, wst_we, wst_clr, sec_ld, busy;
  logic       bypass;
  logic       out_byp;

  int n_vec = 0;
  int n_err = 0;
  int cnt_we, cnt_mac, lat, cyc;

  iir_sos_sequencer #(.NUM_SEC(NUM_SEC), .SEC_W(2)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .sec_idx(sec_idx), .coef_idx(coef_idx), .src_sel(src_sel),
    .acc_load(acc_load), .acc_clr(acc_clr), .mac_en(mac_en), .mac_sub(mac_sub),
    .w0_ld(w0_ld), .wst_we(wst_we), .wst_clr(wst_clr), .sec_ld(sec_ld),
    .busy(busy)
`ifdef IIR_SEQ_BYPASS_EN
    , .bypass(bypass), .out_byp(out_byp)
`endif
  );
`ifndef IIR_SEQ_BYPASS_EN
  assign out_byp = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t obs;
  assign obs = {out_byp, in_ready, out_valid, busy, sec_idx, coef_idx,
                src_sel, acc_load, acc_clr, mac_en, mac_sub, w0_ld, wst_we, wst_clr, sec_ld};

  // strobe field order: src_sel, acc_load, acc_clr, mac_en, mac_sub, w0_ld, wst_we, wst_clr, sec_ld
  function automatic obs_t mk(bit ir, bit ov, bit bz, logic [1:0] sec, logic [2:0] coef,
                              logic [8:0] strb, bit byp);
    return {byp, ir, ov, bz, sec, coef, strb};
  endfunction

  function automatic obs_t rst_vec();
    return mk(0, 0, 1, 2'd0, 3'd0, 9'd0, 0);
  endfunction
  function automatic obs_t init_vec(int s);
    return mk(0, 0, 1, 2'(s), 3'd0, 9'b0_0000_0010, 0);
  endfunction
  function automatic obs_t idle_vec();
    return mk(1, 0, 0, 2'd0, 3'd0, 9'd0, 0);
  endfunction
  function automatic obs_t done_vec(bit byp);
    return mk(0, 1, 1, byp ? 2'd0 : 2'(NUM_SEC - 1), 3'd0, 9'd0, byp);
  endfunction

  // One biquad section = 8 micro-ops: preload, two feedback MACs, w0 capture,
  // three feedforward MACs (first clears acc), state/output update.
  function automatic obs_t sec_vec(int s, int k);
    logic [8:0] st;
    logic [2:0] cf;
    cf = 3'd0;
    case (k)
      0: st = {(s != 0), 8'b1000_0000};
      1: st = 9'b0_0011_0000;
      2: begin st = 9'b0_0011_0000; cf = 3'd1; end
      3: st = 9'b0_0000_1000;
      4: begin st = 9'b0_0110_0000; cf = 3'd2; end
      5: begin st = 9'b0_0010_0000; cf = 3'd3; end
      6: begin st = 9'b0_0010_0000; cf = 3'd4; end
      default: st = 9'b0_0000_0101;
    endcase
    return mk(0, 0, 1, 2'(s), cf, st, 0);
  endfunction

  task automatic chk(input obs_t exp, input string tag);
    @(posedge clk);
    #1;
    n_vec++;
    cyc++;
    cnt_we  += int'(wst_we);
    cnt_mac += int'(mac_en);
    if (out_valid === 1'b1 && lat < 0) lat = cyc;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input int observed, input int expected, input string tag);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset(input int nlow);
    nrst = 1'b0;
    in_valid = 1'b0;
    repeat (nlow) chk(rst_vec(), "reset");
    nrst = 1'b1;
    for (int s = 0; s < NUM_SEC; s++) chk(init_vec(s), "init_clr");
    chk(idle_vec(), "init_to_idle");
  endtask

  task automatic idle_gap(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      out_ready = 1'($urandom);
      chk(idle_vec(), "idle");
    end
  endtask

  // Called with the DUT in IDLE; ends with the DUT back in IDLE.
  task automatic run_sample(input int stall, input bit byp);
    cnt_we = 0; cnt_mac = 0; lat = -1; cyc = 0;
    in_valid = 1'b1;
    bypass = byp;
    out_ready = 1'($urandom);
    if (!byp) begin
      for (int s = 0; s < NUM_SEC; s++)
        for (int k = 0; k < 8; k++) begin
          chk(sec_vec(s, k), "section");
          in_valid  = 1'($urandom);
          bypass    = 1'($urandom);
          out_ready = 1'($urandom);
        end
      out_ready = 1'b0;
      chk(done_vec(0), "done_entry");
    end else begin
      out_ready = 1'b0;
      chk(done_vec(1), "byp_done_entry");
    end
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      chk(done_vec(byp), "backpressure");
    end
    out_ready = 1'b1;
    chk(idle_vec(), "release");
    in_valid = 1'b0;
    chk_int(lat, byp ? 1 : 8 * NUM_SEC + 1, "latency");
    chk_int(cnt_we, byp ? 0 : NUM_SEC, "wst_we_count");
    chk_int(cnt_mac, byp ? 0 : 5 * NUM_SEC, "mac_en_count");
  endtask

  task automatic midop_reset(input int cut, input int nlow);
    in_valid = 1'b1;
    bypass = 1'b0;
    for (int c = 0; c < cut; c++) begin
      chk(sec_vec(c / 8, c % 8), "midop_section");
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
    end
    do_reset(nlow);
  endtask

  initial begin
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bypass = 1'b0;
    cnt_we = 0; cnt_mac = 0; lat = 0; cyc = 0;

    do_reset(2);
    idle_gap(1 + int'($urandom_range(0, 4)));

    run_sample(0, 0);
    idle_gap(2);
    run_sample(10, 0);
    idle_gap(1);

    // back-to-back: next handshake on the first IDLE cycle
    for (int i = 0; i < 4; i++) run_sample(int'($urandom_range(0, 3)), 0);

    for (int i = 0; i < 8; i++) begin
      idle_gap(int'($urandom_range(0, 4)));
`ifdef IIR_SEQ_BYPASS_EN
      run_sample(int'($urandom_range(0, 6)), 1'($urandom));
`else
      run_sample(int'($urandom_range(0, 6)), 1'b0);
`endif
    end

    midop_reset(12, 1);
    run_sample(0, 0);
    for (int i = 0; i < 2; i++) begin
      midop_reset(int'($urandom_range(1, 8 * NUM_SEC - 1)), int'($urandom_range(1, 3)));
      idle_gap(int'($urandom_range(0, 2)));
    end

`ifdef IIR_SEQ_BYPASS_EN
    run_sample(0, 1);
    run_sample(3, 1);
`endif
    run_sample(1, 0);
    idle_gap(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
